// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator with an in-order output FIFO and flush support.
// Optional IMM_GEN_CSR_ZIMM_EN adds out_zimm (CSR*I uimm) carried per FIFO entry.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_imm_control,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [11:0]      out_imm_csr,
    output logic [TAG_W-1:0] out_tag,
`ifdef IMM_GEN_CSR_ZIMM_EN
    output logic [4:0]       out_zimm,
`endif
    output logic             out_illegal
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [XLEN-1:0]  imm_d;
    logic             ill_d;
    logic [31:0]      sx_val;
    logic             use_sx;
    logic [XLEN-1:0]  mem_imm [DEPTH];
    logic [11:0]      mem_csr [DEPTH];
    logic [TAG_W-1:0] mem_tag [DEPTH];
    logic             mem_ill [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    logic             unused_instr_bits;

    // Opcode bits never feed any immediate format.
    assign unused_instr_bits = ^in_instr[6:0];

    // Sign-extending formats build a 32-bit value first, then widen to XLEN.
    always_comb begin
        imm_d  = '0;
        ill_d  = 1'b0;
        sx_val = '0;
        use_sx = 1'b0;
        case (in_imm_control)
            3'b000: begin
                use_sx = 1'b1;
                sx_val = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            3'b001: begin
                use_sx = 1'b1;
                sx_val = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            3'b010: begin
                use_sx = 1'b1;
                sx_val = {in_instr[31:12], 12'b0};
            end
            3'b011: begin
                use_sx = 1'b1;
                sx_val = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                          in_instr[30:25], in_instr[11:8], 1'b0};
            end
            3'b100: begin
                use_sx = 1'b1;
                sx_val = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                          in_instr[20], in_instr[30:21], 1'b0};
            end
            3'b101: imm_d = '0;
            3'b110: begin
                if (XLEN == 64) imm_d = XLEN'(in_instr[25:20]);
                else            imm_d = XLEN'(in_instr[24:20]);
            end
            default: ill_d = 1'b1;
        endcase
        if (use_sx) imm_d = XLEN'($signed(sx_val));
    end

    assign in_ready  = (count < CNT_W'(DEPTH)) && !flush;
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (pop && !push)
                count <= count - CNT_W'(1);
        end
    end

    // Entry storage needs no reset: outputs are gated by out_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_imm[wr_ptr] <= imm_d;
            mem_csr[wr_ptr] <= in_instr[31:20];
            mem_tag[wr_ptr] <= in_tag;
            mem_ill[wr_ptr] <= ill_d;
        end
    end

    assign out_imm     = out_valid ? mem_imm[rd_ptr] : '0;
    assign out_imm_csr = out_valid ? mem_csr[rd_ptr] : '0;
    assign out_tag     = out_valid ? mem_tag[rd_ptr] : '0;
    assign out_illegal = out_valid ? mem_ill[rd_ptr] : 1'b0;

`ifdef IMM_GEN_CSR_ZIMM_EN
    logic [4:0] mem_zimm [DEPTH];
    logic [4:0] zimm_d;

    assign zimm_d = (in_imm_control == 3'b101) ? in_instr[19:15] : 5'd0;

    always_ff @(posedge clk) begin
        if (push) mem_zimm[wr_ptr] <= zimm_d;
    end

    assign out_zimm = out_valid ? mem_zimm[rd_ptr] : 5'd0;
`endif

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, registered immediate generator for the decode stage.
- Accepts a 32-bit instruction plus an immediate-select code over a valid/ready handshake.
- Produces the sign/zero-extended XLEN-wide immediate and the CSR address.
- Buffers results in a small in-order FIFO so decode can absorb execute-stage backpressure without losing instructions.
- Supports flush on branch mispredict or trap.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64; all immediates extend to XLEN.
- DEPTH, 2, output buffer entries; must be >= 2; any value, not only powers of 2.
- TAG_W, 32, width of the sideband tag (typically PC) carried alongside each instruction.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  drop all buffered entries and any input presented this cycle.
- in_valid  input  1  instruction and control valid.
- in_ready  output  1  block can accept this cycle.
- in_instr  input  32  raw instruction word.
- in_imm_control  input  3  immediate select (encoding below).
- in_tag  input  TAG_W  sideband, passed through unchanged.
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer accepts head entry.
- out_imm  output  XLEN  generated immediate.
- out_imm_csr  output  12  CSR address.
- out_tag  output  TAG_W  tag of head entry.
- out_illegal  output  1  head entry had a reserved control code.

Behaviour:
Immediate-select encoding (sx = sign-extend from instr[31] to XLEN):
- 000 I: sx(instr[31:20]).
- 001 S: sx({instr[31:25], instr[11:7]}).
- 010 U: sx({instr[31:12], 12'b0}); upper bits are ones when XLEN=64 and instr[31]=1.
- 011 B: sx({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
- 100 J: sx({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
- 101 CSR: out_imm = 0; out_imm_csr = instr[31:20].
- 110 SHAMT: zero-extended instr[24:20] when XLEN=32; zero-extended instr[25:20] when XLEN=64.
- 111 reserved: out_imm = 0, out_illegal = 1.
- out_imm_csr = instr[31:20] for every code. out_illegal = 0 for all codes except 111.
- The computation is fully combinational into the FIFO write data. No latch inference is permitted; every output is defined for every code.

FIFO and handshake:
- Push when in_valid & in_ready & !flush. Pop when out_valid & out_ready.
- in_ready = (count < DEPTH) & !flush. in_ready does not depend on out_ready, so a full buffer does not accept input even on a pop cycle.
- Latency: an accepted entry appears on the out_* ports on the next rising edge (minimum 1 cycle); no bypass.
- Order is strictly in-order.
- Simultaneous push and pop with 0 < count < DEPTH leaves count unchanged.
- Read and write pointers wrap from DEPTH-1 to 0.
- out_* are stable while out_valid=1 and out_ready=0.
- When empty: out_valid=0 and out_imm, out_imm_csr, out_tag, out_illegal all drive 0.

Flush:
- On the cycle after flush=1: count=0, pointers=0, out_valid=0.
- The input presented during the flush cycle is discarded.
- A pop coinciding with flush is permitted; the popped entry counts as consumed.

Reset:
- rst=1 at a rising edge gives count=0, pointers=0, out_valid=0, all out_* = 0, and in_ready=1 on the following cycle.
- Reset mid-operation discards all entries.
- rst has priority over flush, push and pop.

Optional Feature:
Macro IMM_GEN_CSR_ZIMM_EN.
- When defined, the block adds output port out_zimm (width 5), stored per FIFO entry:
  - Equals instr[19:15] (CSR*I uimm) when the control code is 101; otherwise 0.
  - Equals 0 when empty and on reset.
- When not defined, the port and its storage are absent. All other behaviour is identical.

Test Plan:
1. XLEN=32: push 0xFFF00093 with code 000, out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_imm_csr=0xFFF, out_illegal=0.
2. Push 0xFE20AE23 (code 001), then 0xFFDFF06F (code 100), back-to-back -> out_imm=0xFFFFFFFC on two consecutive cycles, in order, tags preserved.
3. XLEN=64: push 0x800002B7 with code 010 -> out_imm=0xFFFFFFFF80000000. Push 0x03F0D093 with code 110 -> out_imm=0x3F.
4. DEPTH=2, out_ready=0, three consecutive valid pushes -> first two accepted, in_ready=0 on the third, out_* held stable. Raise out_ready -> entries drain in order, then the third is accepted.
5. Buffer full with flush=1 and in_valid=1 in the same cycle -> next cycle out_valid=0, count=0; flushed input never appears. Assert rst mid-stream -> same empty state, all outputs 0.
6. Push 0x3002D073 with code 101 -> out_imm=0, out_imm_csr=0x300, and out_zimm=5 with IMM_GEN_CSR_ZIMM_EN defined. Code 111 -> out_illegal=1, out_imm=0.
